dram_bank_scheduler: RTL and testbench

- Sequences one DRAM access at a time from the L2 request interface into row/column commands: PRE, ACT, a column burst, and periodic refresh.
- Decodes bank/row from the byte address, tracks the open row per bank (open-page policy) and enforces tRP/tRCD/tRFC waits.
- Generates the column address by incrementing from 0 to NUM_OF_COLS-1 over each burst.
- Sits between the L2 request port and the DRAM command/datapath.

---
 rtl/dram_ctrl_pkg.sv | 31 +++
 rtl/dram_refresh_timer.sv | 36 +++
 rtl/dram_bank_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_dram_bank_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and the fixed 7/3/7 request-address layout.
package dram_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_BURST,
    ST_DONE,
    ST_PREA,
    ST_REF,
    ST_WAIT_RFC
  } state_t;

  // Address layout from the MSB down: ignored offset, bank field, row field.
  localparam int ADDR_OFS_BITS  = 7;
  localparam int ADDR_BANK_BITS = 3;
  localparam int ADDR_ROW_BITS  = 7;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises a sticky pending flag on each wrap.
// A wrap coinciding with i_clr keeps the flag set so that interval is not lost.
module dram_refresh_timer #(
  parameter int T_REFI = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_pending
);

  localparam int CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(T_REFI - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/dram_bank_scheduler.sv
// One-at-a-time DRAM access sequencer: PRE/ACT/column burst with open-page tracking and refresh.
// req_ready only in IDLE without refresh pending; first column at 2 (hit), 3+T_RCD (empty), 4+T_RP+T_RCD (conflict).
module dram_bank_scheduler
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RP         = 2,
  parameter int T_RCD        = 2,
  parameter int T_RFC        = 8,
  parameter int T_REFI       = 256,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_op,
  output logic [BW-1:0]         cmd_bank,
  output logic [RW-1:0]         cmd_row,
  output logic [CW-1:0]         cmd_col,
  output logic                  done,
  output logic                  busy
);

  localparam int BANK_MSB = ADDR_WIDTH - ADDR_OFS_BITS - 1;
  localparam int ROW_MSB  = BANK_MSB - ADDR_BANK_BITS;
  localparam int T_MAX_A  = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX    = (T_MAX_A > T_RFC) ? T_MAX_A : T_RFC;
  localparam int WW       = $clog2(T_MAX) + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BW-1:0]           r_bank;
  logic [RW-1:0]           r_row;
  logic                    r_we;
  logic [CW-1:0]           r_col;
  logic [WW-1:0]           r_wait;
  logic [NUM_OF_BANKS-1:0] r_open_vld;
  logic [RW-1:0]           r_open_row [NUM_OF_BANKS];
  logic                    r_ref_seq;
  logic                    r_out_en;

  logic          w_pending;
  logic          w_req_rdy;
  logic          w_accept;
  logic          w_row_hit;
  logic          w_wait_done;
  logic          w_last_col;
  logic [2:0]    w_cmd_op;
  logic          w_done;
  logic [BW-1:0] w_req_bank;
  logic [RW-1:0] w_req_row;
  logic          w_unused_addr;

  dram_refresh_timer #(
    .T_REFI(T_REFI)
  ) u_refresh_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == ST_REF),
    .o_pending(w_pending)
  );

  assign w_req_bank    = req_addr[BANK_MSB -: BW];
  assign w_req_row     = req_addr[ROW_MSB -: RW];
  assign w_unused_addr = ^{req_addr[ADDR_WIDTH-1 -: ADDR_OFS_BITS], req_addr[ROW_MSB-ADDR_ROW_BITS:0]};

  // r_out_en keeps req_ready low while reset is asserted and for the release cycle.
  assign w_req_rdy   = (r_state == ST_IDLE) && r_out_en && !w_pending;
  assign w_accept    = w_req_rdy && req_valid;
  assign w_row_hit   = r_open_vld[r_bank] && (r_open_row[r_bank] == r_row);
  assign w_wait_done = (r_wait == '0);
  assign w_last_col  = (r_col == CW'(NUM_OF_COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_op    = OP_NOP;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_state_nxt = (|r_open_vld) ? ST_PREA : ST_REF;
        end else if (w_accept) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_row_hit) begin
          w_state_nxt = ST_BURST;
        end else if (r_open_vld[r_bank]) begin
          w_state_nxt = ST_PRE;
        end else begin
          w_state_nxt = ST_ACT;
        end
      end
      ST_PRE: begin
        w_cmd_op    = OP_PRE;
        w_state_nxt = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (w_wait_done) begin
          w_state_nxt = r_ref_seq ? ST_REF : ST_ACT;
        end
      end
      ST_ACT: begin
        w_cmd_op    = OP_ACT;
        w_state_nxt = ST_WAIT_RCD;
      end
      ST_WAIT_RCD: begin
        if (w_wait_done) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        w_cmd_op = r_we ? OP_WR : OP_RD;
        if (w_last_col) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_PREA: begin
        w_cmd_op    = OP_PREA;
        w_state_nxt = ST_WAIT_RP;
      end
      ST_REF: begin
        w_cmd_op    = OP_REF;
        w_state_nxt = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        if (w_wait_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank     <= '0;
      r_row      <= '0;
      r_we       <= 1'b0;
      r_col      <= '0;
      r_wait     <= '0;
      r_open_vld <= '0;
      r_ref_seq  <= 1'b0;
      r_out_en   <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_ref_seq <= 1'b1;
          end else if (w_accept) begin
            r_bank <= w_req_bank;
            r_row  <= w_req_row;
            r_we   <= req_we;
          end
        end
        ST_PRE: begin
          r_open_vld[r_bank] <= 1'b0;
          r_wait             <= WW'(T_RP - 1);
        end
        ST_PREA: begin
          r_open_vld <= '0;
          r_wait     <= WW'(T_RP - 1);
        end
        ST_ACT: begin
          r_open_vld[r_bank] <= 1'b1;
          r_wait             <= WW'(T_RCD - 1);
        end
        ST_REF: begin
          r_ref_seq <= 1'b0;
          r_wait    <= WW'(T_RFC - 1);
        end
        ST_WAIT_RP, ST_WAIT_RCD, ST_WAIT_RFC: begin
          if (!w_wait_done) begin
            r_wait <= r_wait - WW'(1);
          end
        end
        ST_BURST: begin
          r_col <= w_last_col ? '0 : r_col + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Row values are only meaningful under r_open_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_ACT) begin
      r_open_row[r_bank] <= r_row;
    end
  end

  assign req_ready = w_req_rdy;
  assign cmd_op    = w_cmd_op;
  assign cmd_valid = (w_cmd_op != OP_NOP);
  assign cmd_bank  = r_bank;
  assign cmd_row   = r_row;
  assign cmd_col   = r_col;
  assign done      = w_done;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Cycle-exact bench: a transaction-level model predicts every command from the open-page rules and refresh interval.
module tb_dram_bank_scheduler;

  localparam int T_RP   = 2;
  localparam int T_RCD  = 2;
  localparam int T_RFC  = 8;
  localparam int T_REFI = 256;
  localparam int NC     = 8;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ACT  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] PRE  = 3'd4;
  localparam logic [2:0] PREA = 3'd5;
  localparam logic [2:0] REF  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [19:0] req_addr = '0;
  logic        req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_bank;
  logic [6:0]  cmd_row;
  logic [2:0]  cmd_col;
  logic        done;
  logic        busy;

  dram_bank_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_bank (cmd_bank),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; refresh becomes pending after every T_REFI-th edge.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;
  bit m_open [8];
  int m_row  [8];
  int m_next_wrap = T_REFI;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic outs_chk(input string tag, input logic [2:0] op, input int bk, input int rw,
                          input int cl, input logic dn, input logic rdy, input logic bsy);
    chk({tag, ".op"}, 32'(cmd_op), 32'(op));
    chk({tag, ".valid"}, 32'(cmd_valid), 32'(op != NOP));
    if (op inside {ACT, PRE, RD, WR}) chk({tag, ".bank"}, 32'(cmd_bank), 32'(bk));
    if (op == ACT) chk({tag, ".row"}, 32'(cmd_row), 32'(rw));
    if (op == RD || op == WR) chk({tag, ".col"}, 32'(cmd_col), 32'(cl));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic tick(input string tag, input logic [2:0] op, input int bk, input int rw,
                      input int cl, input logic dn, input logic rdy, input logic bsy);
    outs_chk(tag, op, bk, rw, cl, dn, rdy, bsy);
    @(negedge clk);
  endtask

  task automatic do_refresh();
    bit any_open;
    int r;
    any_open = 0;
    for (int b = 0; b < 8; b++) any_open |= m_open[b];
    tick("ref_idle", NOP, 0, 0, 0, 0, 0, 0);
    if (any_open) begin
      tick("prea", PREA, 0, 0, 0, 0, 0, 1);
      repeat (T_RP) tick("prea_wait", NOP, 0, 0, 0, 0, 0, 1);
    end
    r = cyc;
    tick("ref", REF, 0, 0, 0, 0, 0, 1);
    repeat (T_RFC) tick("rfc_wait", NOP, 0, 0, 0, 0, 0, 1);
    for (int b = 0; b < 8; b++) m_open[b] = 0;
    m_next_wrap = (r / T_REFI + 1) * T_REFI;
  endtask

  task automatic service_pending();
    while (m_next_wrap <= cyc) do_refresh();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    outs_chk("rst", NOP, 0, 0, 0, 0, 0, 0);
    chk("rst.bank", 32'(cmd_bank), 32'd0);
    chk("rst.row", 32'(cmd_row), 32'd0);
    chk("rst.col", 32'(cmd_col), 32'd0);
    for (int b = 0; b < 8; b++) m_open[b] = 0;
    m_next_wrap = T_REFI;
    repeat (3) @(negedge clk);
    outs_chk("rst_hold", NOP, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    service_pending();
    tick("idle", NOP, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic run_req(input logic [19:0] addr, input logic we, input int abort_col);
    int bk;
    int rw;
    logic [2:0] col_op;
    bk = int'(addr[12:10]);
    rw = int'(addr[9:3]);
    col_op = we ? WR : RD;
    req_addr  = addr;
    req_we    = we;
    req_valid = 1'b1;
    service_pending();
    tick("accept", NOP, 0, 0, 0, 0, 1, 0);
    req_valid = 1'b0;
    req_addr  = 20'($urandom);
    req_we    = ~we;
    tick("check", NOP, 0, 0, 0, 0, 0, 1);
    if (!(m_open[bk] && m_row[bk] == rw)) begin
      if (m_open[bk]) begin
        tick("pre", PRE, bk, 0, 0, 0, 0, 1);
        repeat (T_RP) tick("rp_wait", NOP, 0, 0, 0, 0, 0, 1);
      end
      tick("act", ACT, bk, rw, 0, 0, 0, 1);
      repeat (T_RCD) tick("rcd_wait", NOP, 0, 0, 0, 0, 0, 1);
      m_open[bk] = 1;
      m_row[bk]  = rw;
    end
    for (int k = 0; k < NC; k++) begin
      if (k == abort_col) begin
        outs_chk("abort_col", col_op, bk, rw, k, 0, 0, 1);
        apply_reset();
        return;
      end
      tick("col", col_op, bk, rw, k, 0, 0, 1);
    end
    tick("done", NOP, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    logic [19:0] a;
    @(negedge clk);
    apply_reset();
    repeat (2) idle_cycle();

    run_req(20'h00C08, 1'b0, -1);
    run_req(20'h00C08, 1'b1, -1);
    run_req(20'h00C10, 1'b0, -1);
    run_req(20'h00028, 1'b0, -1);
    run_req(20'h01C28, 1'b1, -1);
    run_req(20'h00028, 1'b1, -1);
    run_req(20'h01C28, 1'b0, -1);

    while (cyc < m_next_wrap) idle_cycle();
    run_req(20'h00028, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      a = 20'($urandom);
      a[12:10] = 3'($urandom_range(0, 7));
      a[9:3]   = 7'($urandom_range(0, 3));
      run_req(a, 1'($urandom_range(0, 1)), -1);
    end

    run_req(20'h00C08, 1'b0, -1);
    run_req(20'h00C08, 1'b0, 3);
    repeat (2) idle_cycle();
    run_req(20'h00C08, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no end of test, required end of test");
    $fatal(1);
  end

endmodule
